// File: rtl/onedconv_mc_pkg.sv
// onedconv_mc_pkg: shared FSM state encoding and default field widths for the
// one-dimensional convolution row controller (onedconv_mc and its drain unit).
package onedconv_mc_pkg;

    localparam int DEF_BITWIDTH_ROW       = 4;
    localparam int DEF_BITWIDTH_IF_ROWS   = 10;
    localparam int DEF_BITWIDTH_OF_COLUMS = 11;
    localparam int DEF_BITWIDTH_STRIDE    = 4;
    localparam int DEF_BITWIDTH_PAD       = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ROW = 3'd1,
        ST_ACCUM    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/onedconv_mc_drain.sv
// onedconv_mc_drain: walks the output-column index from 0 to of_colums_i-1
// with a valid/ready handshake. Index and valid are held until a transfer.
// finish_o flags the cycle in which the last column is accepted.
module onedconv_mc_drain
    import onedconv_mc_pkg::*;
#(
    parameter int BITWIDTH_OF_COLUMS = DEF_BITWIDTH_OF_COLUMS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [BITWIDTH_OF_COLUMS-1:0] of_colums_i,
    input  logic                          o_ready_i,
    output logic                          o_valid_o,
    output logic [BITWIDTH_OF_COLUMS-1:0] o_col_o,
    output logic                          finish_o
);

    logic                          valid_q, valid_d;
    logic [BITWIDTH_OF_COLUMS-1:0] col_q, col_d;
    logic                          last_col;
    logic                          xfer;

    assign last_col = (col_q == (of_colums_i - BITWIDTH_OF_COLUMS'(1)));
    assign xfer     = valid_q && o_ready_i;
    assign finish_o = xfer && last_col;

    // Next drain index: load on start, advance on each accepted transfer.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        col_d   = col_q;
        if (start_i) begin
            valid_d = 1'b1;
            col_d   = '0;
        end else if (xfer) begin
            if (last_col) begin
                valid_d = 1'b0;
                col_d   = '0;
            end else begin
                col_d = col_q + BITWIDTH_OF_COLUMS'(1);
            end
        end
    end

    // Drain registers; async reset clears them even mid-drain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so all flops update from pre-edge values.
        if (!rst_n) begin
            valid_q <= 1'b0;
            col_q   <= '0;
        end else begin
            valid_q <= valid_d;
            col_q   <= col_d;
        end
    end

    assign o_valid_o = valid_q;
    assign o_col_o   = col_q;

endmodule

// File: rtl/onedconv_mc.sv
// onedconv_mc: per-PE row controller for a 1-D convolution pass. Accepts the
// input rows this weight row contributes to, strobes window start/accumulate
// per pixel, then drains one output row before waiting for the next.
// Optional zero padding is built only when ONEDCONV_MC_PAD_EN is defined.
module onedconv_mc
    import onedconv_mc_pkg::*;
#(
    parameter int BITWIDTH_ROW       = DEF_BITWIDTH_ROW,
    parameter int BITWIDTH_IF_ROWS   = DEF_BITWIDTH_IF_ROWS,
    parameter int BITWIDTH_OF_COLUMS = DEF_BITWIDTH_OF_COLUMS,
    parameter int BITWIDTH_STRIDE    = DEF_BITWIDTH_STRIDE,
    parameter int BITWIDTH_PAD       = DEF_BITWIDTH_PAD
) (
    input  logic                          ONEDCONV_MC_Clk,
    input  logic                          ONEDCONV_MC_Reset,
    input  logic                          ONEDCONV_MC_Start,
    input  logic                          ONEDCONV_MC_Enable,
    input  logic [BITWIDTH_ROW-1:0]       ONEDCONV_MC_Row,
    input  logic [BITWIDTH_IF_ROWS-1:0]   ONEDCONV_MC_If_Rows,
    input  logic [BITWIDTH_ROW-1:0]       ONEDCONV_MC_W_Rows,
    input  logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_MC_Of_Colums,
    input  logic [BITWIDTH_STRIDE-1:0]    ONEDCONV_MC_Conv_Stride,
    input  logic [BITWIDTH_IF_ROWS-1:0]   ONEDCONV_MC_Current_Row,
    input  logic                          ONEDCONV_MC_Row_Start,
    input  logic                          ONEDCONV_MC_Row_End,
    input  logic                          ONEDCONV_MC_Pix_Valid,
    input  logic                          ONEDCONV_MC_O_Ready,
`ifdef ONEDCONV_MC_PAD_EN
    input  logic [BITWIDTH_PAD-1:0]       ONEDCONV_MC_Pad,
`endif
    output logic                          ONEDCONV_MC_Set_En,
    output logic                          ONEDCONV_MC_Acc_En,
    output logic                          ONEDCONV_MC_Row_Accept,
    output logic                          ONEDCONV_MC_O_Valid,
    output logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_MC_O_Col,
`ifdef ONEDCONV_MC_PAD_EN
    output logic                          ONEDCONV_MC_Pad_Row,
`endif
    output logic                          ONEDCONV_MC_Busy,
    output logic                          ONEDCONV_MC_Done,
    output logic                          ONEDCONV_MC_Overrun
);

    // Row arithmetic is two bits wider than the row index so that
    // If_Rows + 2*Pad + Row never wraps.
    localparam int EXT = BITWIDTH_IF_ROWS + 2;
    typedef logic [EXT-1:0] ext_t;

    state_e                        state_q, state_d;
    ext_t                          next_row_q, next_row_d;
    logic [BITWIDTH_STRIDE-1:0]    phase_q, phase_d;
    logic [BITWIDTH_OF_COLUMS-1:0] win_cnt_q, win_cnt_d;
    logic                          overrun_q, overrun_d;
    logic                          pad_row_q, pad_row_d;
    logic                          row_accept_q, row_accept_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic [BITWIDTH_PAD-1:0]       pad;
    logic [BITWIDTH_STRIDE-1:0]    stride_eff, phase_inc;
    ext_t                          if_rows_ext, w_rows_ext, row_ext, cur_ext, pad_ext;
    ext_t                          avail_rows, final_row, stride_ext, next_row_adv;
    logic                          empty_map, row_hit, is_pad_row, adv_past_end;
    logic                          accum_live, drain_start, drain_finish;

`ifdef ONEDCONV_MC_PAD_EN
    assign pad        = ONEDCONV_MC_Pad;
    assign is_pad_row = (cur_ext < pad_ext) || (cur_ext >= (if_rows_ext + pad_ext));
`else
    assign pad        = '0;
    assign is_pad_row = 1'b0;
`endif

    assign if_rows_ext  = EXT'(ONEDCONV_MC_If_Rows);
    assign w_rows_ext   = EXT'(ONEDCONV_MC_W_Rows);
    assign row_ext      = EXT'(ONEDCONV_MC_Row);
    assign cur_ext      = EXT'(ONEDCONV_MC_Current_Row);
    assign pad_ext      = EXT'(pad);
    assign avail_rows   = if_rows_ext + (pad_ext << 1);
    assign empty_map    = w_rows_ext > avail_rows;
    assign final_row    = avail_rows - w_rows_ext + row_ext;

    // A zero stride behaves as stride 1.
    assign stride_eff   = (ONEDCONV_MC_Conv_Stride == '0) ? BITWIDTH_STRIDE'(1)
                                                          : ONEDCONV_MC_Conv_Stride;
    assign stride_ext   = EXT'(stride_eff);
    assign phase_inc    = phase_q + BITWIDTH_STRIDE'(1);
    assign next_row_adv = next_row_q + stride_ext;
    assign adv_past_end = next_row_adv > final_row;

    assign row_hit = ONEDCONV_MC_Row_Start && (cur_ext == next_row_q) &&
                     (cur_ext >= row_ext) && (cur_ext <= final_row);

    // Window strobes are combinational so they line up with the pixel itself.
    assign accum_live         = (state_q == ST_ACCUM) && ONEDCONV_MC_Enable;
    assign ONEDCONV_MC_Set_En = accum_live && ONEDCONV_MC_Pix_Valid && (phase_q == '0) &&
                                (win_cnt_q < ONEDCONV_MC_Of_Colums);
    assign ONEDCONV_MC_Acc_En = accum_live && ONEDCONV_MC_Pix_Valid && !pad_row_q;

    // Next-state and registered-output logic of the row controller.
    always_comb begin
        state_d      = state_q;
        next_row_d   = next_row_q;
        phase_d      = phase_q;
        win_cnt_d    = win_cnt_q;
        overrun_d    = overrun_q;
        pad_row_d    = pad_row_q;
        row_accept_d = 1'b0;
        drain_start  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ONEDCONV_MC_Start) begin
                    overrun_d  = 1'b0;
                    next_row_d = row_ext;
                    state_d    = empty_map ? ST_DONE : ST_WAIT_ROW;
                end
            end
            ST_WAIT_ROW: begin
                if (ONEDCONV_MC_Enable) begin
                    if (next_row_q > final_row) begin
                        state_d = ST_DONE;
                    end else if (row_hit) begin
                        state_d      = ST_ACCUM;
                        row_accept_d = 1'b1;
                        phase_d      = '0;
                        win_cnt_d    = '0;
                        pad_row_d    = is_pad_row;
                    end
                end
            end
            ST_ACCUM: begin
                if (ONEDCONV_MC_Row_Start) overrun_d = 1'b1;
                if (ONEDCONV_MC_Enable) begin
                    if (ONEDCONV_MC_Pix_Valid) begin
                        phase_d = (phase_inc == stride_eff) ? '0 : phase_inc;
                    end
                    if (ONEDCONV_MC_Set_En) win_cnt_d = win_cnt_q + BITWIDTH_OF_COLUMS'(1);
                    if (ONEDCONV_MC_Row_End) begin
                        pad_row_d = 1'b0;
                        if (ONEDCONV_MC_Of_Colums == '0) begin
                            next_row_d = next_row_adv;
                            state_d    = adv_past_end ? ST_DONE : ST_WAIT_ROW;
                        end else begin
                            state_d     = ST_DRAIN;
                            drain_start = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (ONEDCONV_MC_Row_Start) overrun_d = 1'b1;
                if (drain_finish) begin
                    next_row_d = next_row_adv;
                    state_d    = adv_past_end ? ST_DONE : ST_WAIT_ROW;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge ONEDCONV_MC_Clk or negedge ONEDCONV_MC_Reset) begin
        if (!ONEDCONV_MC_Reset) begin
            state_q      <= ST_IDLE;
            next_row_q   <= '0;
            phase_q      <= '0;
            win_cnt_q    <= '0;
            overrun_q    <= 1'b0;
            pad_row_q    <= 1'b0;
            row_accept_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_row_q   <= next_row_d;
            phase_q      <= phase_d;
            win_cnt_q    <= win_cnt_d;
            overrun_q    <= overrun_d;
            pad_row_q    <= pad_row_d;
            row_accept_q <= row_accept_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    onedconv_mc_drain #(
        .BITWIDTH_OF_COLUMS(BITWIDTH_OF_COLUMS)
    ) u_drain (
        .clk        (ONEDCONV_MC_Clk),
        .rst_n      (ONEDCONV_MC_Reset),
        .start_i    (drain_start),
        .of_colums_i(ONEDCONV_MC_Of_Colums),
        .o_ready_i  (ONEDCONV_MC_O_Ready),
        .o_valid_o  (ONEDCONV_MC_O_Valid),
        .o_col_o    (ONEDCONV_MC_O_Col),
        .finish_o   (drain_finish)
    );

    assign ONEDCONV_MC_Row_Accept = row_accept_q;
    assign ONEDCONV_MC_Busy       = busy_q;
    assign ONEDCONV_MC_Done       = done_q;
    assign ONEDCONV_MC_Overrun    = overrun_q;
`ifdef ONEDCONV_MC_PAD_EN
    assign ONEDCONV_MC_Pad_Row    = pad_row_q;
`endif

endmodule

// File: doc/onedconv_mc.md
ONEDCONV_MC -- requirements
Module: onedconv_mc

Interface
REQ-001 SHALL have parameter BITWIDTH_ROW, default 4, width of weight-row offset.
REQ-002 SHALL have parameter BITWIDTH_IF_ROWS, default 10, width of input-row index and count.
REQ-003 SHALL have parameter BITWIDTH_OF_COLUMS, default 11, width of output-column count and index.
REQ-004 SHALL have parameter BITWIDTH_STRIDE, default 4, width of stride.
REQ-005 SHALL have parameter BITWIDTH_PAD, default 3, width of padding (used only under ONEDCONV_MC_PAD_EN).
REQ-006 SHALL have ports, in order (clock and reset first):
- ONEDCONV_MC_Clk  in  1  single clock, rising edge.
- ONEDCONV_MC_Reset  in  1  asynchronous, active-low reset.
- ONEDCONV_MC_Start  in  1  pulse, begins a feature-map pass.
- ONEDCONV_MC_Enable  in  1  stalls WAIT_ROW/ACCUM when low.
- ONEDCONV_MC_Row  in  BITWIDTH_ROW  weight row handled by this PE.
- ONEDCONV_MC_If_Rows  in  BITWIDTH_IF_ROWS  input rows.
- ONEDCONV_MC_W_Rows  in  BITWIDTH_ROW  weight rows.
- ONEDCONV_MC_Of_Colums  in  BITWIDTH_OF_COLUMS  output columns per row.
- ONEDCONV_MC_Conv_Stride  in  BITWIDTH_STRIDE  stride; 0 treated as 1.
- ONEDCONV_MC_Current_Row  in  BITWIDTH_IF_ROWS  row index, valid with Row_Start.
- ONEDCONV_MC_Row_Start / ONEDCONV_MC_Row_End  in  1 each  row-boundary pulses.
- ONEDCONV_MC_Pix_Valid  in  1  one input pixel this cycle.
- ONEDCONV_MC_O_Ready  in  1  downstream accepts output.
- ONEDCONV_MC_Pad  in  BITWIDTH_PAD  rows of zero padding (macro only).
- ONEDCONV_MC_Set_En / ONEDCONV_MC_Acc_En / ONEDCONV_MC_Row_Accept  out  1 each  window start, accumulate, row taken.
- ONEDCONV_MC_O_Valid  out  1;  ONEDCONV_MC_O_Col  out  BITWIDTH_OF_COLUMS  drain index.
- ONEDCONV_MC_Pad_Row  out  1  current row is padding (macro only).
- ONEDCONV_MC_Busy / ONEDCONV_MC_Done / ONEDCONV_MC_Overrun  out  1 each.

Function
REQ-007 SHALL implement FSM IDLE, WAIT_ROW, ACCUM, DRAIN, DONE; Busy=1 outside IDLE.
REQ-008 IDLE: Start -> WAIT_ROW, next_row:=Row, Overrun cleared; Start in other states ignored.
REQ-009 SHALL compute FinalRow = If_Rows + 2*Pad - W_Rows + Row at BITWIDTH_IF_ROWS+2 bits, no wrap; if W_Rows > If_Rows+2*Pad, Start -> DONE directly.
REQ-010 WAIT_ROW: Row_Start with Current_Row==next_row and Row<=Current_Row<=FinalRow -> ACCUM, Row_Accept=1 that cycle; mismatched rows ignored; next_row>FinalRow -> DONE.
REQ-011 ACCUM: Acc_En=Pix_Valid; Set_En=Pix_Valid & stride_phase==0 & win_cnt<Of_Colums; phase wraps at Conv_Stride; win_cnt increments on Set_En; Row_End -> DRAIN.
REQ-012 DRAIN: O_Valid=1, O_Col=drain index from 0; transfer on O_Valid&O_Ready; O_Valid/O_Col stable until transfer; after index Of_Colums-1, next_row+=stride -> WAIT_ROW, or DONE if next_row>FinalRow; Of_Colums==0 skips DRAIN.
REQ-013 Enable=0 SHALL freeze state and counters in WAIT_ROW/ACCUM, forcing Set_En/Acc_En/Row_Accept to 0; DRAIN unaffected.
REQ-014 Row_Start during ACCUM or DRAIN SHALL set sticky Overrun; row dropped; Row_End outside ACCUM ignored.
REQ-015 DONE SHALL pulse Done for one cycle, then -> IDLE.
REQ-016 All outputs SHALL be registered except Set_En/Acc_En (combinational from Pix_Valid, zero latency).

Reset
REQ-017 Reset low SHALL asynchronously force IDLE, all counters 0, all outputs 0, including mid-drain.
REQ-018 Reset release SHALL be synchronised by the integrator; block needs no extra cycles.

Configuration
REQ-019 Macro ONEDCONV_MC_PAD_EN defined: Pad and Pad_Row ports exist; Pad_Row=1 in ACCUM when Current_Row<Pad or >=If_Rows+Pad; Acc_En forced 0 while Pad_Row.
REQ-020 Macro undefined: Pad and Pad_Row ports absent, Pad treated as 0.

Structure
REQ-021 Package onedconv_mc_pkg SHALL hold the FSM state encoding and default widths.
REQ-022 Drain counter/handshake SHALL be sub-module onedconv_mc_drain.

Verification
REQ-023 If_Rows=8, W_Rows=3, Row=1, stride=1, Of_Colums=6 -> rows 1..6 accepted, 6 drains of 6 outputs, one Done.
REQ-024 Stride=2, Row=0, If_Rows=8, W_Rows=3 -> rows 0,2,4 accepted; row 1 ignored, no Overrun.
REQ-025 ACCUM with 12 Pix_Valid, stride=2, Of_Colums=5 -> Set_En on pixels 0,2,4,6,8 only.
REQ-026 DRAIN with O_Ready low 3 cycles -> O_Valid held, O_Col=0 stable, no count advance.
REQ-027 Row_Start during DRAIN -> Overrun=1 until next Start; Reset low mid-ACCUM -> IDLE, outputs 0.
REQ-028 With macro, Pad=1, If_Rows=4, W_Rows=3, Row=0 -> rows 0..3 accepted, Pad_Row=1 on row 0, Acc_En=0 there.
